symbol_spreader: RTL

- Parametrised successor to the fixed two-nibble symbol-to-chip mapper in the 802.15.4 O-QPSK transmit path.
- Accepts IN_WIDTH-bit data words over a valid/ready handshake and splits each word into 4-bit symbols, LSB nibble first.
- Maps each symbol to its 32-chip DSSS sequence and serialises the chips, CHIPS_PER_BEAT chips per beat, over a second valid/ready handshake toward the modulator.

---
 rtl/spreader_pkg.sv | 25 ++
 rtl/symbol_spreader_if.sv | 24 ++
 rtl/chip_serializer.sv | 43 ++++
 rtl/symbol_spreader.sv | 94 +++++++++
 4 files changed

// File: rtl/spreader_pkg.sv
// Shared constants, FSM state type and chip table for the O-QPSK symbol spreader.
// Chip c0 of every sequence sits in bit 31.
package spreader_pkg;

  localparam int SYM_W         = 4;
  localparam int CHIPS_PER_SYM = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Entries 1..7 are entry 0 rotated right by 4n; entries 8..15 invert the odd chips.
  localparam logic [CHIPS_PER_SYM-1:0] CHIP_TABLE [16] = '{
    32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
    32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
    32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
    32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
  };

  function automatic logic [SYM_W-1:0] nibble_at(input logic [31:0] word, input int idx);
    return SYM_W'(word >> (SYM_W * idx));
  endfunction

endpackage

// File: rtl/symbol_spreader_if.sv
// Word-in / chip-beat-out handshake bundle for the symbol spreader.
interface symbol_spreader_if #(
  parameter int IN_WIDTH       = 8,
  parameter int CHIPS_PER_BEAT = 32
);
  logic [IN_WIDTH-1:0]       in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHIPS_PER_BEAT-1:0] out_chips;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sym_start;
  logic                      out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_chips, out_valid, out_sym_start, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_chips, out_valid, out_sym_start, out_last
  );
endinterface

// File: rtl/chip_serializer.sv
// Loadable 32-chip shift register emitting CHIPS_PER_BEAT chips per beat, earliest chip on the MSB.
module chip_serializer
  import spreader_pkg::*;
#(
  parameter int CHIPS_PER_BEAT = 32
) (
  input  logic                      pclk,
  input  logic                      RESET,
  input  logic                      load,
  input  logic [CHIPS_PER_SYM-1:0]  load_chips,
  input  logic                      advance,
  output logic [CHIPS_PER_BEAT-1:0] chips,
  output logic                      sym_start,
  output logic                      sym_end
);
  localparam int B  = CHIPS_PER_SYM / CHIPS_PER_BEAT;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  logic [CHIPS_PER_SYM-1:0] shift_p0;
  logic [BW-1:0]            beat_idx;

  // Data path carries no reset; the beat counter is control.
  always_ff @(posedge pclk) begin
    if (load)
      shift_p0 <= load_chips;
    else if (advance)
      shift_p0 <= shift_p0 << CHIPS_PER_BEAT;
  end

  always_ff @(posedge pclk) begin
    if (RESET)
      beat_idx <= '0;
    else if (load)
      beat_idx <= '0;
    else if (advance)
      beat_idx <= beat_idx + 1'b1;
  end

  assign chips     = shift_p0[CHIPS_PER_SYM-1 -: CHIPS_PER_BEAT];
  assign sym_start = (beat_idx == '0);
  assign sym_end   = (beat_idx == BW'(B - 1));

endmodule

// File: rtl/symbol_spreader.sv
// 802.15.4 symbol-to-chip spreader: splits words into nibbles (LSB first) and streams DSSS chip beats.
module symbol_spreader
  import spreader_pkg::*;
#(
  parameter int IN_WIDTH       = 8,
  parameter int CHIPS_PER_BEAT = 32
) (
  input  logic               pclk,
  input  logic               RESET,
  symbol_spreader_if.slave   bus
);
  localparam int S   = IN_WIDTH / SYM_W;
  localparam int SIW = (S > 1) ? $clog2(S) : 1;

  state_e                    state, nxt_state;
  logic [IN_WIDTH-1:0]       word_q;
  logic [SIW-1:0]            sym_idx, nxt_idx;
  logic                      out_valid_c, in_ready_c, xfer, word_last, accept;
  logic                      load, advance;
  logic [SYM_W-1:0]          load_sym;
  logic [CHIPS_PER_BEAT-1:0] ser_chips;
  logic                      sym_start, sym_end;

  assign nxt_idx = sym_idx + 1'b1;

  always_ff @(posedge pclk) begin
    if (RESET)
      state <= ST_IDLE;
    else
      state <= nxt_state;
  end

  always_comb begin
    nxt_state   = state;
    load        = 1'b0;
    advance     = 1'b0;
    load_sym    = bus.in_data[SYM_W-1:0];
    out_valid_c = (state == ST_SHIFT) && !RESET;
    xfer        = out_valid_c && bus.out_ready;
    word_last   = out_valid_c && sym_end && (sym_idx == SIW'(S - 1));
    // Taking the next word on the last-beat transfer is what removes the bubble between words.
    in_ready_c  = !RESET && ((state == ST_IDLE) || (xfer && word_last));
    accept      = in_ready_c && bus.in_valid;

    case (state)
      ST_IDLE:  if (accept) nxt_state = ST_SHIFT;
      ST_SHIFT: if (xfer && word_last) nxt_state = accept ? ST_SHIFT : ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase

    if (accept) begin
      load = 1'b1;
    end else if (xfer && sym_end && !word_last) begin
      load     = 1'b1;
      load_sym = nibble_at(32'(word_q), int'(nxt_idx));
    end else if (xfer && !sym_end) begin
      advance = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (accept)
      word_q <= bus.in_data;
  end

  always_ff @(posedge pclk) begin
    if (RESET)
      sym_idx <= '0;
    else if (accept)
      sym_idx <= '0;
    else if (xfer && sym_end && !word_last)
      sym_idx <= nxt_idx;
  end

  chip_serializer #(
    .CHIPS_PER_BEAT(CHIPS_PER_BEAT)
  ) u_ser (
    .pclk       (pclk),
    .RESET      (RESET),
    .load       (load),
    .load_chips (CHIP_TABLE[load_sym]),
    .advance    (advance),
    .chips      (ser_chips),
    .sym_start  (sym_start),
    .sym_end    (sym_end)
  );

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_chips     = out_valid_c ? ser_chips : '0;
  assign bus.out_sym_start = out_valid_c && sym_start;
  assign bus.out_last      = word_last;

endmodule
